// File: rtl/timer_pkg.sv
// Shared encodings for the timer sequencer: display modes, FSM state types,
// and counter widths.
package timer_pkg;
  localparam logic [1:0] MODE_COUNTDOWN = 2'd0;
  localparam logic [1:0] MODE_STOPWATCH = 2'd1;
  localparam logic [1:0] MODE_CLOCK     = 2'd2;
  localparam logic [1:0] MODE_ALARM_SET = 2'd3;

  localparam int CENTI_PER_SEC = 100;
  localparam int SW_W          = 32;

  typedef enum logic [1:0] {CD_IDLE, CD_RUN, CD_PAUSE, CD_RING} cd_state_t;
  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_STOP} sw_state_t;
endpackage

// File: rtl/button_edge_detector.sv
// Rising-edge press detector: one-cycle press per low-to-high transition.
module button_edge_detector (
  input  logic clockSignal,
  input  logic resetN,
  input  logic btn,
  output logic press
);
  logic btnPrev;

  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) btnPrev <= 1'b0;
    else         btnPrev <= btn;

  assign press = btn & ~btnPrev;
endmodule

// File: rtl/timer_mode_controller.sv
// Front-panel sequencer: mode select, countdown with ring, stopwatch with
// lap capture. Both counters advance on tick regardless of displayed mode.
module timer_mode_controller
  import timer_pkg::*;
#(
  parameter int LAP_DEPTH  = 16,
  parameter int RING_TICKS = 3000,
  parameter int PRESET_W   = 24
) (
  input  logic                         clockSignal,
  input  logic                         resetN,
  input  logic                         tick,
  input  logic                         modeButton,
  input  logic                         startOrStop,
  input  logic                         splitOrReset,
  input  logic [PRESET_W-1:0]          presetCentiseconds,
  output logic [1:0]                   mode,
  output logic [PRESET_W-1:0]          countdownRemaining,
  output logic [SW_W-1:0]              stopwatchCount,
  output logic                         lapWriteEn,
  output logic [$clog2(LAP_DEPTH)-1:0] lapWriteIndex,
  output logic [SW_W-1:0]              lapWriteData,
  output logic [7:0]                   lapTotal,
  output logic                         lapClear,
  output logic                         ringSound,
  output logic                         cdRunning,
  output logic                         swRunning
);
  localparam int IW = $clog2(LAP_DEPTH);
  localparam int RW = $clog2(RING_TICKS + 1);

  logic [2:0] btns, presses;
  assign btns = {splitOrReset, startOrStop, modeButton};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    button_edge_detector u_det (
      .clockSignal(clockSignal), .resetN(resetN),
      .btn(btns[g]), .press(presses[g])
    );
  end

  // Priority resolver: ring ack swallows everything, then mode, then start, then split.
  cd_state_t cdState, cdNext;
  sw_state_t swState, swNext;
  logic ack, modeAdv, ssEff, srEff, cdStart, cdSplit, swStart, swSplit;

  always_comb begin
    ack     = ringSound & |presses;
    modeAdv = ~ringSound & presses[0];
    ssEff   = ~ringSound & ~presses[0] & presses[1];
    srEff   = ~ringSound & ~presses[0] & ~presses[1] & presses[2];
    cdStart = ssEff & (mode == MODE_COUNTDOWN);
    cdSplit = srEff & (mode == MODE_COUNTDOWN);
    swStart = ssEff & (mode == MODE_STOPWATCH);
    swSplit = srEff & (mode == MODE_STOPWATCH);
  end

  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN)      mode <= MODE_COUNTDOWN;
    else if (modeAdv) mode <= mode + 2'd1;

  // Countdown FSM
  logic [PRESET_W-1:0] remNext;
  logic [RW-1:0]       ringCnt, ringNext;

  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) begin
      cdState            <= CD_IDLE;
      countdownRemaining <= '0;
      ringCnt            <= '0;
    end else begin
      cdState            <= cdNext;
      countdownRemaining <= remNext;
      ringCnt            <= ringNext;
    end

  always_comb begin
    cdNext   = cdState;
    remNext  = countdownRemaining;
    ringNext = ringCnt;
    case (cdState)
      CD_IDLE:
        if (cdStart && presetCentiseconds != '0) begin
          remNext = presetCentiseconds;
          cdNext  = CD_RUN;
        end
      CD_RUN: begin
        if (tick && countdownRemaining != '0)
          remNext = countdownRemaining - PRESET_W'(1);
        // expiry takes precedence over a same-cycle pause
        if (tick && countdownRemaining == PRESET_W'(1)) begin
          cdNext   = CD_RING;
          ringNext = '0;
        end else if (cdStart) cdNext = CD_PAUSE;
      end
      CD_PAUSE:
        if (cdStart) cdNext = CD_RUN;
        else if (cdSplit) begin
          remNext = '0;
          cdNext  = CD_IDLE;
        end
      CD_RING:
        if (ack) cdNext = CD_IDLE;
        else if (tick) begin
          ringNext = ringCnt + RW'(1);
          if (ringNext == RW'(RING_TICKS)) cdNext = CD_IDLE;
        end
      default: cdNext = CD_IDLE;
    endcase
  end

  // Stopwatch FSM with lap capture
  logic [SW_W-1:0] cntTick, cntNext, dataNext;
  logic [IW-1:0]   idxNext;
  logic [7:0]      totNext;
  logic            weNext, clrNext;

  always_ff @(posedge clockSignal or negedge resetN)
    if (!resetN) begin
      swState        <= SW_IDLE;
      stopwatchCount <= '0;
      lapTotal       <= '0;
      lapWriteEn     <= 1'b0;
      lapWriteIndex  <= '0;
      lapWriteData   <= '0;
      lapClear       <= 1'b0;
    end else begin
      swState        <= swNext;
      stopwatchCount <= cntNext;
      lapTotal       <= totNext;
      lapWriteEn     <= weNext;
      lapWriteIndex  <= idxNext;
      lapWriteData   <= dataNext;
      lapClear       <= clrNext;
    end

  always_comb begin
    swNext   = swState;
    cntNext  = stopwatchCount;
    totNext  = lapTotal;
    weNext   = 1'b0;
    clrNext  = 1'b0;
    idxNext  = lapWriteIndex;
    dataNext = lapWriteData;
    cntTick  = (tick && stopwatchCount != '1) ? stopwatchCount + SW_W'(1) : stopwatchCount;
    case (swState)
      SW_IDLE: if (swStart) swNext = SW_RUN;
      SW_RUN: begin
        cntNext = cntTick;
        if (swStart) swNext = SW_STOP;
        else if (swSplit) begin
          weNext   = 1'b1;
          dataNext = cntTick;
          idxNext  = lapTotal[IW-1:0];
          if (lapTotal != 8'hFF) totNext = lapTotal + 8'd1;
        end
      end
      SW_STOP:
        if (swStart) swNext = SW_RUN;
        else if (swSplit) begin
          cntNext = '0;
          totNext = '0;
          clrNext = 1'b1;
          swNext  = SW_IDLE;
        end
      default: swNext = SW_IDLE;
    endcase
  end

  assign ringSound = (cdState == CD_RING);
  assign cdRunning = (cdState == CD_RUN);
  assign swRunning = (swState == SW_RUN);
endmodule
